// File: rtl/wam_pkg.sv
// Whack-a-mole shared definitions: FSM states, difficulty encoding and the
// per-difficulty spawn delay / mole lifetime / points tables.
package wam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_SPAWN_WAIT = 2'b01,
        ST_ACTIVE     = 2'b10,
        ST_GAME_OVER  = 2'b11
    } wam_state_e;

    typedef enum logic [1:0] {
        DIFF_EASY    = 2'b00,
        DIFF_MEDIUM  = 2'b01,
        DIFF_HARD    = 2'b10,
        DIFF_DEFAULT = 2'b11
    } wam_diff_e;

    localparam logic [7:0] STREAK_BONUS_PTS = 8'd50;
    localparam logic [3:0] STREAK_BONUS_MIN = 4'd4;
    localparam logic [3:0] STREAK_MAX       = 4'd15;

    // Milliseconds spent in SPAWN_WAIT before a new set of moles appears.
    function automatic logic [15:0] spawn_delay_ms(input wam_diff_e d);
        logic [15:0] v;
        case (d)
            DIFF_EASY:   v = 16'd800;
            DIFF_MEDIUM: v = 16'd600;
            DIFF_HARD:   v = 16'd400;
            default:     v = 16'd700;
        endcase
        return v;
    endfunction

    // Milliseconds a set of moles stays up before the round counts as missed.
    function automatic logic [15:0] lifetime_ms(input wam_diff_e d);
        logic [15:0] v;
        case (d)
            DIFF_EASY:   v = 16'd1500;
            DIFF_MEDIUM: v = 16'd1200;
            DIFF_HARD:   v = 16'd900;
            default:     v = 16'd1500;
        endcase
        return v;
    endfunction

    // Points awarded for each mole hit.
    function automatic logic [7:0] hit_points(input wam_diff_e d);
        logic [7:0] v;
        case (d)
            DIFF_EASY:   v = 8'd10;
            DIFF_MEDIUM: v = 8'd20;
            DIFF_HARD:   v = 8'd30;
            default:     v = 8'd15;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/wam_ms_timer.sv
// Millisecond timer for the whack-a-mole engine: synchronous clear has
// priority, otherwise counts ms ticks and sticks at all-ones.
module wam_ms_timer #(
    parameter int TIMER_W = 11
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               ms_tick_i,
    output logic [TIMER_W-1:0] count_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Next count: clear wins, then saturating increment on each tick.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {TIMER_W{1'b0}};
        end else if (ms_tick_i && (count_q != {TIMER_W{1'b1}})) begin
            count_d = count_q + TIMER_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= {TIMER_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/whack_a_mole_engine.sv
// Whack-a-mole game engine: spawns moles from a random source, scores
// whacks, tracks streak and lives, and ends the game on quit or when all
// lives are spent.
// Optional build macro WAM_STREAK_BONUS_EN: adds a fixed bonus in every hit
// cycle that leaves the streak at 4 or more.
module whack_a_mole_engine
    import wam_pkg::*;
#(
    parameter int N_MOLES    = 9,
    parameter int MAX_ACTIVE = 2,
    parameter int LIVES      = 3,
    parameter int SCORE_W    = 16,
    parameter int TIMER_W    = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ms_tick,
    input  logic               start,
    input  logic [N_MOLES-1:0] switches,
    input  logic [1:0]         difficulty,
    input  logic [15:0]        random_value,
    output logic [N_MOLES-1:0] mole_positions,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         streak,
    output logic [2:0]         lives,
    output logic               spawn_req,
    output logic               game_over
);

    // Score arithmetic is done wide enough to hold any single-cycle award.
    localparam int SUM_W = ((SCORE_W > 12) ? SCORE_W : 12) + 1;

    // Number of set bits in a mole-wide vector.
    function automatic logic [4:0] popcount(input logic [N_MOLES-1:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < N_MOLES; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // Spawn mask: one hole per random nibble, duplicates merge, never empty.
    function automatic logic [N_MOLES-1:0] build_mask(input logic [15:0] rv);
        logic [N_MOLES-1:0] m;
        logic [3:0]         nib;
        int                 idx;
        m = {N_MOLES{1'b0}};
        for (int k = 0; k < MAX_ACTIVE; k++) begin
            nib    = rv[4*k +: 4];
            idx    = int'(nib) % N_MOLES;
            m[idx] = 1'b1;
        end
        return m;
    endfunction

    // Registered state
    wam_state_e         state_q, state_d;
    wam_diff_e          diff_q, diff_d;
    logic [N_MOLES-1:0] mask_q, mask_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         streak_q, streak_d;
    logic [2:0]         lives_q, lives_d;
    logic               spawn_req_q, spawn_req_d;
    logic               game_over_q, game_over_d;
    logic               start_prev_q;
    logic [N_MOLES-1:0] sw_prev_q;

    // Combinational helpers
    logic               start_edge_s;
    logic [N_MOLES-1:0] sw_edge_s;
    logic [N_MOLES-1:0] hit_s;
    logic [N_MOLES-1:0] wrong_s;
    logic [N_MOLES-1:0] mask_left_s;
    logic [N_MOLES-1:0] spawn_mask_s;
    logic [4:0]         n_hit_s;
    logic [5:0]         streak_sum_s;
    logic [3:0]         streak_new_s;
    logic [11:0]        add_pts_s;
    logic [11:0]        bonus_s;
    logic [SUM_W-1:0]   score_sum_s;
    logic [SCORE_W-1:0] score_sat_s;
    logic [TIMER_W-1:0] timer_s;
    logic [31:0]        timer_ext_s;
    logic               spawn_due_s;
    logic               life_due_s;
    logic [2:0]         lives_dec_s;
    logic               timer_clear_s;

    assign start_edge_s = start & ~start_prev_q;
    assign sw_edge_s    = switches & ~sw_prev_q;

    // Hit/wrong classification and saturating score/streak candidates.
    always_comb begin
        hit_s        = sw_edge_s & mask_q;
        wrong_s      = sw_edge_s & ~mask_q;
        mask_left_s  = mask_q & ~hit_s;
        spawn_mask_s = build_mask(random_value);
        n_hit_s      = popcount(hit_s);
        streak_sum_s = 6'(streak_q) + 6'(n_hit_s);
        if (wrong_s != {N_MOLES{1'b0}}) begin
            streak_new_s = 4'd0;
        end else if (streak_sum_s > 6'(STREAK_MAX)) begin
            streak_new_s = STREAK_MAX;
        end else begin
            streak_new_s = streak_sum_s[3:0];
        end
        bonus_s = 12'd0;
`ifdef WAM_STREAK_BONUS_EN
        if ((n_hit_s != 5'd0) && (streak_new_s >= STREAK_BONUS_MIN)) begin
            bonus_s = 12'(STREAK_BONUS_PTS);
        end else begin
            bonus_s = 12'd0;
        end
`else
        bonus_s = 12'd0;
`endif
        add_pts_s   = (12'(hit_points(diff_q)) * 12'(n_hit_s)) + bonus_s;
        score_sum_s = SUM_W'(score_q) + SUM_W'(add_pts_s);
        if (score_sum_s > SUM_W'({SCORE_W{1'b1}})) begin
            score_sat_s = {SCORE_W{1'b1}};
        end else begin
            score_sat_s = score_sum_s[SCORE_W-1:0];
        end
        timer_ext_s = 32'(timer_s);
        spawn_due_s = (timer_ext_s == 32'(spawn_delay_ms(diff_q)));
        life_due_s  = (timer_ext_s == 32'(lifetime_ms(diff_q)));
        lives_dec_s = (lives_q != 3'd0) ? (lives_q - 3'd1) : 3'd0;
    end

    // Game FSM next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        diff_d      = diff_q;
        mask_d      = mask_q;
        score_d     = score_q;
        streak_d    = streak_q;
        lives_d     = lives_q;
        spawn_req_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_edge_s) begin
                    diff_d   = wam_diff_e'(difficulty);
                    score_d  = {SCORE_W{1'b0}};
                    streak_d = 4'd0;
                    lives_d  = 3'(LIVES);
                    mask_d   = {N_MOLES{1'b0}};
                    state_d  = ST_SPAWN_WAIT;
                end else begin
                    mask_d  = {N_MOLES{1'b0}};
                    state_d = state_q;
                end
            end
            ST_SPAWN_WAIT: begin
                if (start_edge_s) begin
                    mask_d  = {N_MOLES{1'b0}};
                    state_d = ST_GAME_OVER;
                end else if (spawn_due_s) begin
                    mask_d      = spawn_mask_s;
                    spawn_req_d = 1'b1;
                    state_d     = ST_ACTIVE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ACTIVE: begin
                if (start_edge_s) begin
                    // Quit: score, streak and lives are frozen as they are.
                    mask_d  = {N_MOLES{1'b0}};
                    state_d = ST_GAME_OVER;
                end else begin
                    score_d  = score_sat_s;
                    streak_d = streak_new_s;
                    mask_d   = mask_left_s;
                    if (mask_left_s == {N_MOLES{1'b0}}) begin
                        // Clearing the last mole beats a same-cycle timeout.
                        state_d = ST_SPAWN_WAIT;
                    end else if (life_due_s) begin
                        mask_d   = {N_MOLES{1'b0}};
                        streak_d = 4'd0;
                        lives_d  = lives_dec_s;
                        state_d  = (lives_dec_s == 3'd0) ? ST_GAME_OVER : ST_SPAWN_WAIT;
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            default: begin
                mask_d  = {N_MOLES{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
        game_over_d   = (state_d == ST_GAME_OVER);
        timer_clear_s = (state_d != state_q);
    end

    // State, outputs and edge-detect history registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            diff_q       <= DIFF_EASY;
            mask_q       <= {N_MOLES{1'b0}};
            score_q      <= {SCORE_W{1'b0}};
            streak_q     <= 4'd0;
            lives_q      <= 3'd0;
            spawn_req_q  <= 1'b0;
            game_over_q  <= 1'b0;
            start_prev_q <= 1'b0;
            sw_prev_q    <= {N_MOLES{1'b0}};
        end else begin
            state_q      <= state_d;
            diff_q       <= diff_d;
            mask_q       <= mask_d;
            score_q      <= score_d;
            streak_q     <= streak_d;
            lives_q      <= lives_d;
            spawn_req_q  <= spawn_req_d;
            game_over_q  <= game_over_d;
            start_prev_q <= start;
            sw_prev_q    <= switches;
        end
    end

    wam_ms_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .clear_i   (timer_clear_s),
        .ms_tick_i (ms_tick),
        .count_o   (timer_s)
    );

    assign mole_positions = mask_q;
    assign score          = score_q;
    assign streak         = streak_q;
    assign lives          = lives_q;
    assign spawn_req      = spawn_req_q;
    assign game_over      = game_over_q;

endmodule

// File: doc/whack_a_mole_engine.md
WHACK_A_MOLE_ENGINE -- requirements
Module: whack_a_mole_engine

Interface
REQ-001 SHALL have parameter N_MOLES, default 9, number of holes (2..16).
REQ-002 SHALL have parameter MAX_ACTIVE, default 2, moles spawned per round (1..4).
REQ-003 SHALL have parameter LIVES, default 3, missed rounds allowed per game (1..7).
REQ-004 SHALL have parameters SCORE_W, default 16, score width; TIMER_W, default 11, ms timer width.
REQ-005 SHALL have ports:
- clk  in  1  clock.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- ms_tick  in  1  one-cycle pulse per millisecond.
- start  in  1  button level.
- switches  in  N_MOLES  whack switches, levels.
- difficulty  in  2  00 easy, 01 medium, 10 hard, 11 default.
- random_value  in  16  random source.
- mole_positions  out  N_MOLES  live mole mask.
- score  out  SCORE_W  game score.
- streak  out  4  consecutive-hit count.
- lives  out  3  remaining lives.
- spawn_req  out  1  one-cycle spawn pulse.
- game_over  out  1  high in GAME_OVER.

Function
REQ-006 SHALL rising-edge-detect start and each switch with registered previous values; edges outside ACTIVE are ignored except start.
REQ-007 SHALL implement states IDLE, SPAWN_WAIT, ACTIVE, GAME_OVER; timer clears on every state entry, counts ms_tick, saturates at all-ones.
REQ-008 SHALL, on start edge in IDLE or GAME_OVER: latch difficulty, clear score and streak, load lives=LIVES, enter SPAWN_WAIT.
REQ-009 SHALL use latched difficulty tables (spawn delay ms / mole lifetime ms / points): easy 800/1500/10, medium 600/1200/20, hard 400/900/30, default 700/1500/15.
REQ-010 SHALL, in SPAWN_WAIT when timer equals spawn delay: load mask, pulse spawn_req for that cycle only, enter ACTIVE.
REQ-011 SHALL form mask as OR over k<MAX_ACTIVE of one-hot(random_value[4k+3:4k] mod N_MOLES); duplicates collapse; mask is never zero.
REQ-012 SHALL, in ACTIVE per cycle: hit = edges & mask; clear hit bits; score += points × popcount(hit), saturating at 2^SCORE_W-1; streak += popcount(hit), saturating at 15.
REQ-013 SHALL treat edges & ~mask as wrong whack: no score change, streak cleared; with simultaneous hit, hits score and streak ends 0.
REQ-014 SHALL enter SPAWN_WAIT when mask becomes zero.
REQ-015 SHALL, when timer equals lifetime with mask nonzero: clear mask, streak=0, lives-=1, enter SPAWN_WAIT, or GAME_OVER if lives reaches 0; last hit in the same cycle wins over timeout.
REQ-016 SHALL treat start edge in SPAWN_WAIT or ACTIVE as quit: clear mask, enter GAME_OVER, hold score.
REQ-017 SHALL hold score, streak and lives in GAME_OVER with mask zero.

Reset
REQ-018 SHALL on reset_n low immediately force IDLE, mask 0, score 0, streak 0, lives 0, timer 0, spawn_req 0, game_over 0, edge registers 0.
REQ-019 SHALL restart cleanly from IDLE after reset asserted mid-game; no state survives.

Configuration
REQ-020 SHALL, with WAM_STREAK_BONUS_EN defined, add 50 extra points in any hit cycle leaving streak >= 4 (same saturation); without it no bonus is added and streak still counts.

Structure
REQ-021 SHALL place state enum, difficulty enum and delay/lifetime/points tables in package wam_pkg.
REQ-022 SHALL instantiate sub-module wam_ms_timer (clear, ms_tick, saturating TIMER_W count).

Verification
REQ-023 Medium, start edge, 600 ticks, random_value=16'h0031 -> spawn_req one cycle, mask 9'b000001010.
REQ-024 Then switch 1 rise -> score 20, streak 1, mask 9'b000001000; switch 3 rise -> score 40, mask 0, state SPAWN_WAIT.
REQ-025 random_value=16'h00C3, N_MOLES=9 -> mask 9'b000001000 (12 mod 9 = 3, duplicate collapsed).
REQ-026 Medium, no whacks, 3 rounds of 1200 ticks -> lives 3,2,1,0, game_over=1 after third timeout.
REQ-027 Mask 9'b000001010, switches 0 and 1 rise together -> score +20, streak 0, mask 9'b000001000.
REQ-028 With WAM_STREAK_BONUS_EN, medium, four consecutive single hits -> score 20,40,60,130; reset_n low in ACTIVE -> all outputs 0 next observation.
